i2s_transmitter: RTL and testbench



---
 rtl/i2s_transmitter_if.sv | 27 ++
 rtl/i2s_transmitter.sv | 161 ++++++++++++++++
 tb/tb_i2s_transmitter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_transmitter_if.sv
// Sample-pair handshake and serial-audio pins of the I2S transmitter.
// The master side feeds sample pairs and play control; the slave side is the transmitter.
interface i2s_transmitter_if #(
  parameter int unsigned DATA_W = 24
);
  logic              play_in;
  logic              tick_in;
  logic [DATA_W-1:0] audio0_in;
  logic [DATA_W-1:0] audio1_in;
  logic              req_out;
  logic              sck_out;
  logic              ws_out;
  logic              sdo_out;
  logic              busy_out;
  logic              underrun_out;
  logic              overrun_out;

  modport master (
    output play_in, tick_in, audio0_in, audio1_in,
    input  req_out, sck_out, ws_out, sdo_out, busy_out, underrun_out, overrun_out
  );

  modport slave (
    input  play_in, tick_in, audio0_in, audio1_in,
    output req_out, sck_out, ws_out, sdo_out, busy_out, underrun_out, overrun_out
  );
endinterface

// File: rtl/i2s_transmitter.sv
// Left-justified I2S transmitter: one-entry sample-pair buffer feeding a 2*DATA_W-slot
// serializer, with play/drain control and underrun/overrun flags. All outputs registered.
module i2s_transmitter #(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned SCK_HALF = 4
) (
  input logic              clk,
  input logic              rst_n,
  i2s_transmitter_if.slave bus
);
  localparam int unsigned FrameW = 2 * DATA_W;
  localparam int unsigned HcntW  = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int unsigned SlotW  = $clog2(FrameW);
  localparam logic [HcntW-1:0] HcntMax  = HcntW'(SCK_HALF - 1);
  localparam logic [SlotW-1:0] SlotMax  = SlotW'(FrameW - 1);
  localparam logic [SlotW-1:0] LeftLast = SlotW'(DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

  state_e              state_q, state_d;
  logic [FrameW-1:0]   buf_q, buf_d;
  logic                buf_valid_q, buf_valid_d;
  logic [FrameW-1:0]   sreg_q, sreg_d;
  logic [SlotW-1:0]    slot_q, slot_d;
  logic [HcntW-1:0]    hcnt_q, hcnt_d;
  logic                sck_q, sck_d;
  logic                ws_q, ws_d;
  logic                sdo_q, sdo_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                underrun_q, underrun_d;
  logic                overrun_q, overrun_d;

  logic hc_end, frame_end, load;

  assign hc_end    = (hcnt_q == HcntMax);
  assign frame_end = hc_end && sck_q && (slot_q == SlotMax);
  // A stop request at the very frame boundary ends playback instead of starting a new frame.
  assign load      = bus.play_in &&
                     (((state_q == StFill) && buf_valid_q) || ((state_q == StRun) && frame_end));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.play_in) state_d = StFill;
      StFill: begin
        if (!bus.play_in)    state_d = StIdle;
        else if (buf_valid_q) state_d = StRun;
      end
      StRun: begin
        if (frame_end)        state_d = bus.play_in ? StRun : StIdle;
        else if (!bus.play_in) state_d = StDrain;
      end
      StDrain: if (frame_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    buf_d       = buf_q;
    buf_valid_d = buf_valid_q;
    sreg_d      = sreg_q;
    slot_d      = slot_q;
    hcnt_d      = hcnt_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sdo_d       = sdo_q;
    req_d       = 1'b0;
    underrun_d  = 1'b0;
    overrun_d   = 1'b0;
    busy_d      = (state_d != StIdle);

    if (state_q == StIdle || state_d == StIdle) begin
      buf_d       = '0;
      buf_valid_d = 1'b0;
      slot_d      = '0;
      hcnt_d      = '0;
      sck_d       = 1'b0;
      ws_d        = 1'b0;
      sdo_d       = 1'b0;
      req_d       = (state_q == StIdle) && bus.play_in;
    end else begin
      // A load consumes the old pair even when a new one lands on the same edge.
      if (bus.tick_in) begin
        buf_d       = {bus.audio0_in, bus.audio1_in};
        buf_valid_d = 1'b1;
        overrun_d   = buf_valid_q && !load;
      end else if (load) begin
        buf_valid_d = 1'b0;
      end

      if (load) begin
        req_d      = 1'b1;
        underrun_d = !buf_valid_q;
        sreg_d     = buf_valid_q ? buf_q : '0;
        slot_d     = '0;
        hcnt_d     = '0;
        sck_d      = 1'b0;
        ws_d       = 1'b0;
        sdo_d      = buf_valid_q && buf_q[FrameW-1];
      end else if (state_q == StRun || state_q == StDrain) begin
        if (!hc_end) begin
          hcnt_d = hcnt_q + HcntW'(1);
        end else if (!sck_q) begin
          sck_d  = 1'b1;
          hcnt_d = '0;
        end else begin
          slot_d = slot_q + SlotW'(1);
          hcnt_d = '0;
          sck_d  = 1'b0;
          sreg_d = {sreg_q[FrameW-2:0], 1'b0};
          sdo_d  = sreg_q[FrameW-2];
          ws_d   = (slot_q >= LeftLast);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q       <= '0;
      buf_valid_q <= 1'b0;
      sreg_q      <= '0;
      slot_q      <= '0;
      hcnt_q      <= '0;
      sck_q       <= 1'b0;
      ws_q        <= 1'b0;
      sdo_q       <= 1'b0;
      req_q       <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      buf_valid_q <= buf_valid_d;
      sreg_q      <= sreg_d;
      slot_q      <= slot_d;
      hcnt_q      <= hcnt_d;
      sck_q       <= sck_d;
      ws_q        <= ws_d;
      sdo_q       <= sdo_d;
      req_q       <= req_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.req_out      = req_q;
  assign bus.sck_out      = sck_q;
  assign bus.ws_out       = ws_q;
  assign bus.sdo_out      = sdo_q;
  assign bus.busy_out     = busy_q;
  assign bus.underrun_out = underrun_q;
  assign bus.overrun_out  = overrun_q;
endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed + randomized bench for i2s_transmitter: captures each serial frame on sck rising
// edges and compares it with the pair a simple delivery model says should be on the wire.
module tb_i2s_transmitter;
  localparam int DW    = 24;
  localparam int H     = 4;
  localparam int P     = 2 * H;
  localparam int FRAME = 2 * DW * P;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2s_transmitter_if #(.DATA_W(DW)) bus ();

  i2s_transmitter #(.DATA_W(DW), .SCK_HALF(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [6:0] outs;
  assign outs = {bus.req_out, bus.sck_out, bus.ws_out, bus.sdo_out, bus.busy_out,
                 bus.underrun_out, bus.overrun_out};

  int n_chk = 0;
  int n_pass = 0;

  // Delivery model: the pair waiting for the next frame start, plus a pair that arrives on
  // the very edge a frame starts (it waits for the frame after).
  logic [2*DW-1:0] m_pend, m_carry;
  logic            m_wait, m_carry_v;
  int              m_over;
  logic [2*DW-1:0] e_data;
  logic            e_under;

  logic [2*DW-1:0] cap_d, cap_w;
  int              c_rise, c_req, c_und, c_ovr, c_bad, c_busy_lo;
  logic            c_req0, c_sdo0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [2*DW-1:0] rnd48();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[2*DW-1:0];
  endfunction

  task automatic model_tick(input int i, input logic [2*DW-1:0] p);
    if (i == FRAME - 1) begin
      m_carry   = p;
      m_carry_v = 1'b1;
    end else begin
      if (m_wait) m_over++;
      m_pend = p;
      m_wait = 1'b1;
    end
  endtask

  task automatic drive_tick(input logic [2*DW-1:0] p);
    bus.tick_in   = 1'b1;
    bus.audio0_in = p[2*DW-1:DW];
    bus.audio1_in = p[DW-1:0];
  endtask

  // Runs one full frame starting at the negedge right after its load edge.
  task automatic run_frame(input int ta, input logic [2*DW-1:0] pa,
                           input int tb, input logic [2*DW-1:0] pb, input int stop_i);
    logic ps, pd, pw;
    e_data    = m_wait ? m_pend : '0;
    e_under   = !m_wait;
    m_wait    = m_carry_v;
    m_pend    = m_carry;
    m_carry_v = 1'b0;
    m_over    = 0;
    cap_d = '0; cap_w = '0;
    c_rise = 0; c_req = 0; c_und = 0; c_ovr = 0; c_bad = 0; c_busy_lo = 0;
    ps = 1'b0; pd = 1'b0; pw = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      bus.tick_in = 1'b0;
      if (i == 0) begin
        c_req0 = bus.req_out;
        c_sdo0 = bus.sdo_out;
      end
      c_req += int'(bus.req_out);
      c_und += int'(bus.underrun_out);
      c_ovr += int'(bus.overrun_out);
      if (!bus.busy_out) c_busy_lo++;
      if (bus.sck_out && !ps) begin
        c_rise++;
        cap_d = {cap_d[2*DW-2:0], bus.sdo_out};
        cap_w = {cap_w[2*DW-2:0], bus.ws_out};
        if (i % P != H) c_bad++;
      end
      if (!bus.sck_out && ps && (i % P != 0)) c_bad++;
      if (i > 0 && (bus.sdo_out != pd || bus.ws_out != pw) && (i % P != 0)) c_bad++;
      ps = bus.sck_out; pd = bus.sdo_out; pw = bus.ws_out;
      if (i == ta) begin drive_tick(pa); model_tick(i, pa); end
      if (i == tb) begin drive_tick(pb); model_tick(i, pb); end
      if (i == stop_i) bus.play_in = 1'b0;
    end
  endtask

  task automatic check_frame(input string tag);
    check({tag, ".data"},  cap_d, e_data);
    check({tag, ".ws"},    cap_w, {{DW{1'b0}}, {DW{1'b1}}});
    check({tag, ".req"},   {c_req0, c_req}, {1'b1, 32'd1});
    check({tag, ".rise"},  c_rise, 2 * DW);
    check({tag, ".tmg"},   c_bad, 0);
    check({tag, ".busy"},  c_busy_lo, 0);
    check({tag, ".under"}, c_und, int'(e_under));
    check({tag, ".over"},  c_ovr, m_over);
  endtask

  task automatic start_and_fill(input logic [2*DW-1:0] p, input string tag);
    @(negedge clk);
    check({tag, ".start"}, {bus.req_out, bus.busy_out, bus.sck_out}, 3'b110);
    @(negedge clk);
    check({tag, ".fill"}, {bus.req_out, bus.busy_out, bus.sck_out, bus.sdo_out}, 4'b0100);
    drive_tick(p);
    @(negedge clk);
    bus.tick_in = 1'b0;
    check({tag, ".prelat"}, {bus.req_out, bus.sdo_out, bus.busy_out}, 3'b001);
    m_wait = 1'b1; m_pend = p; m_carry_v = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*DW-1:0] p1, p2, px, py, pa, pb;
    int act, nt, ta, tb;
    rst_n = 1'b0;
    bus.play_in = 1'b0; bus.tick_in = 1'b0; bus.audio0_in = '0; bus.audio1_in = '0;
    m_wait = 1'b0; m_pend = '0; m_carry = '0; m_carry_v = 1'b0; m_over = 0;
    repeat (3) @(negedge clk);
    check("reset_outs", outs, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_quiet", outs, 0);

    // Basic frame
    bus.play_in = 1'b1;
    start_and_fill({24'hA50F0F, 24'h5AF0F0}, "f1");
    run_frame(-1, '0, -1, '0, -1);
    check("f1.msb", c_sdo0, 1'b1);
    check_frame("f1");

    // Underrun frame, with two ticks 3 cycles apart (overrun)
    p1 = {24'h000001, rnd48()} ; p1[2*DW-1:DW] = 24'h000001;
    p2 = rnd48(); p2[2*DW-1:DW] = 24'h000002;
    run_frame(100, p1, 103, p2, -1);
    check_frame("f2_underrun");

    // Carries L=2; tick mid-frame plus a tick on the load edge
    px = rnd48(); py = rnd48();
    run_frame(200, px, FRAME - 1, py, -1);
    check("f3.left", cap_d[2*DW-1:DW], 24'h000002);
    check_frame("f3_overrun_data");
    run_frame(-1, '0, -1, '0, -1);
    check_frame("f4_collision_old");

    // Randomized frames
    for (int k = 0; k < 5; k++) begin
      nt = int'($urandom_range(0, 2));
      ta = (nt == 0) ? -1 : int'($urandom_range(0, FRAME - 2));
      tb = (nt == 2) ? int'($urandom_range(ta + 1, FRAME - 1)) : -1;
      pa = rnd48(); pb = rnd48();
      run_frame(ta, pa, tb, pb, -1);
      check_frame($sformatf("rnd%0d", k));
    end

    // Stop at slot 10: frame completes, then quiet
    run_frame(-1, '0, -1, '0, 10 * P + H);
    check_frame("f_drain");
    @(negedge clk);
    check("drain_quiet", {bus.sck_out, bus.ws_out, bus.sdo_out, bus.busy_out, bus.req_out}, 0);
    act = 0;
    repeat (40) begin
      @(negedge clk);
      act += int'(bus.req_out) + int'(bus.sck_out) + int'(bus.busy_out);
    end
    check("drain_no_req", act, 0);

    // Stop while in FILL
    bus.play_in = 1'b1;
    @(negedge clk);
    check("fabort.req", {bus.req_out, bus.busy_out}, 2'b11);
    bus.play_in = 1'b0;
    @(negedge clk);
    check("fabort.idle", {bus.busy_out, bus.sck_out, bus.req_out}, 0);
    act = 0;
    repeat (30) begin
      @(negedge clk);
      act += int'(bus.sck_out) + int'(bus.req_out) + int'(bus.busy_out);
    end
    check("fabort.quiet", act, 0);
    m_wait = 1'b0; m_carry_v = 1'b0;

    // Reset in the middle of slot 30
    bus.play_in = 1'b1;
    start_and_fill(rnd48(), "rst");
    repeat (30 * P + 1) @(negedge clk);
    check("pre_reset_ws", {bus.ws_out, bus.busy_out}, 2'b11);
    rst_n = 1'b0;
    #1;
    check("async_reset", outs, 0);
    @(negedge clk);
    rst_n = 1'b1;
    start_and_fill(rnd48(), "restart");
    run_frame(-1, '0, -1, '0, 10);
    check_frame("f_restart");
    @(negedge clk);
    check("final_quiet", outs, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
